axi_burst_master: RTL and testbench
===================================

# axi_burst_master

Parametrised AXI4 full-protocol master that executes one INCR burst per command, either read or write, with a configurable beat length per command. It sits between core-side engines (cache refill/writeback, DMA) and the AXI interconnect. Core-side data flows through valid/ready streams, and each command ends with a single completion pulse carrying the merged response. Illegal commands are rejected locally, with no bus activity: lengths above the maximum, and bursts that would cross a 4 KB boundary.

## Interface
Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h40000000, added to every command address
- C_M_AXI_MAX_BURST_LEN, 16, maximum beats per command (1..256)
- C_M_AXI_ID_WIDTH, 1, ID width; IDs are driven 0
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (32, 64 or 128)

Ports (clock and reset first). One clock; reset is synchronous and active-low.
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  synchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_rw  in  1  command direction: 1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte offset of the burst
- cmd_len  in  8  beats minus 1
- wr_valid / wr_ready  in / out  1  write-data stream handshake
- wr_data / wr_strb  in  DATA_W / DATA_W/8  write data and byte strobes
- rd_valid / rd_ready  out / in  1  read-data stream handshake
- rd_data  out  DATA_W  read data
- rd_last  out  1  final beat of the read stream
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  completion response
- M_AXI_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,VALID} out, M_AXI_AWREADY in: AXI4 write-address channel
- M_AXI_W{DATA,STRB,LAST,VALID} out, M_AXI_WREADY in: AXI4 write-data channel
- M_AXI_B{ID,RESP,VALID} in, M_AXI_BREADY out: AXI4 write-response channel
- M_AXI_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,VALID} out, M_AXI_ARREADY in: AXI4 read-address channel
- M_AXI_R{ID,DATA,RESP,LAST,VALID} in, M_AXI_RREADY out: AXI4 read-data channel

## Operation
Constant AXI fields:
- SIZE = log2(DATA_W/8); BURST = 2'b01 (INCR); CACHE = 4'b0010; LOCK, PROT, QOS, ID = 0.

FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.

Command capture (IDLE):
- cmd_ready = (state == IDLE).
- On handshake, register len, direction and a = (cmd_addr + BASE_ADDR) with the low log2(DATA_W/8) bits forced to 0.
- Clear the beat counter and the error accumulator.

Local rejection:
- Reject if cmd_len ≥ MAX_BURST_LEN, or if (a[11:0] + (cmd_len+1)·DATA_W/8) > 4096.
- A rejected command goes directly to DONE with done_resp = 2'b10 (SLVERR); no AXI valid is raised.

Otherwise, next state is WADDR when cmd_rw = 1, else RADDR.

WADDR:
- AWVALID = 1, AWADDR = a, AWLEN = len.
- On AWREADY, go to WDATA.

WDATA (pass-through with a beat counter):
- WVALID = wr_valid; wr_ready = WREADY; WDATA/WSTRB = wr_data/wr_strb.
- WLAST = (cnt == len).
- The counter increments on each W handshake; the WLAST handshake moves to WRESP.
- wr_ready = 0 in every other state.

WRESP:
- BREADY = 1.
- On BVALID, done_resp = BRESP; go to DONE.

RADDR:
- ARVALID = 1, ARADDR = a, ARLEN = len.
- On ARREADY, go to RDATA.

RDATA:
- rd_valid = RVALID; RREADY = rd_ready; rd_data = RDATA; rd_last = (cnt == len).
- The error accumulator keeps the maximum RRESP seen across beats.
- If RLAST differs from (cnt == len) on any beat, the accumulator is forced to ≥ 2'b10.
- On the handshake with cnt == len, go to DONE.

DONE:
- done_valid = 1 for one cycle, with done_resp holding the final value; then IDLE.

Width rules:
- The beat counter is 8 bits and never wraps, because len ≤ 255.
- Address arithmetic is modulo 2^ADDR_W.

## Timing
Reset:
- On reset: state = IDLE.
- Every AXI VALID and READY is 0, except that cmd_ready = 1.
- done_valid = 0, done_resp = 0, counter = 0.

Latency:
- A command accepted at edge N drives AWVALID/ARVALID from cycle N+1.
- A rejected command pulses done_valid in cycle N+1.
- done_valid follows the last B or R handshake by exactly 1 cycle.
- At most one command is outstanding; the next cmd_ready is seen the cycle after done_valid.

Handshake rules:
- Once raised, AWVALID/ARVALID stay asserted, with stable address and length, until READY.
- AW and W never overlap: W starts only after the AW handshake.
- The W and R paths are combinational pass-through; a stalled stream on either side stalls the bus.

Reset mid-operation: in-flight transactions are abandoned and every output returns to its reset value on the next edge.

## Test plan
- Write, cmd_addr = 0x100, len = 3, WREADY always 1: AWADDR = 0x40000100, AWLEN = 3, 4 W beats with WLAST on beat 4, BRESP = 0 → done_resp = 00.
- Read, len = 15, rd_ready toggling 1/0, random RVALID gaps: 16 beats delivered in order, rd_last only on beat 16, done_valid exactly once.
- Write, cmd_len = 16 with MAX = 16 → done_valid in cycle N+1, done_resp = 10, AWVALID never asserted.
- Read, cmd_addr = 0xFF8, len = 3, DATA_W = 32 → rejected as a 4 KB crossing, done_resp = 10; the same command at 0xFF0 is accepted.
- Read, len = 3, RRESP = 10 on beat 2 → done_resp = 10; RLAST asserted on beat 2 (early) → done_resp ≥ 10.
- M_AXI_ARESETN pulled low during WDATA beat 2 → next edge: all valids 0, cmd_ready = 1; a subsequent write completes normally.

Source files
------------

// File: rtl/axi_burst_master.sv
// AXI4 master that turns one core-side command into a single INCR read or write burst.
// Core streams pass straight through to the bus; each command ends in one done_valid pulse.
module axi_burst_master #(
   parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
   parameter int          C_M_AXI_MAX_BURST_LEN      = 16,
   parameter int          C_M_AXI_ID_WIDTH           = 1,
   parameter int          C_M_AXI_ADDR_WIDTH         = 32,
   parameter int          C_M_AXI_DATA_WIDTH         = 32
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_rw,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [7:0]                        cmd_len,
   input  logic                              wr_valid,
   output logic                              wr_ready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wr_strb,
   output logic                              rd_valid,
   input  logic                              rd_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rd_data,
   output logic                              rd_last,
   output logic                              done_valid,
   output logic [1:0]                        done_resp,
   output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [7:0]                        M_AXI_AWLEN,
   output logic [2:0]                        M_AXI_AWSIZE,
   output logic [1:0]                        M_AXI_AWBURST,
   output logic                              M_AXI_AWLOCK,
   output logic [3:0]                        M_AXI_AWCACHE,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic [3:0]                        M_AXI_AWQOS,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WLAST,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [7:0]                        M_AXI_ARLEN,
   output logic [2:0]                        M_AXI_ARSIZE,
   output logic [1:0]                        M_AXI_ARBURST,
   output logic                              M_AXI_ARLOCK,
   output logic [3:0]                        M_AXI_ARCACHE,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic [3:0]                        M_AXI_ARQOS,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RLAST,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY,
   output logic [2:0]                        dbg_state
);

   localparam int AW_W  = C_M_AXI_ADDR_WIDTH;
   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam logic [AW_W-1:0] LSB_MASK = AW_W'(BYTES - 1);
   localparam logic [15:0]     BYTES16  = 16'(BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [AW_W-1:0]   addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        resp_q, resp_d;

   logic [AW_W-1:0]   cmd_addr_abs, cmd_addr_aln;
   logic [15:0]       span;
   logic              reject;
   logic              last_beat;
   logic [1:0]        acc;
   logic              unused_ok;

   // Handshakes: a transfer happens on any edge where valid && ready; valid never waits on ready,
   // and address channels hold valid, address and length stable until ready.
   always_comb begin
      cmd_addr_abs = cmd_addr + AW_W'(C_M_TARGET_SLAVE_BASE_ADDR);
      cmd_addr_aln = cmd_addr_abs & ~LSB_MASK;
      span         = {4'd0, cmd_addr_aln[11:0]} + (16'(cmd_len) + 16'd1) * BYTES16;
      reject       = ({1'b0, cmd_len} >= 9'(C_M_AXI_MAX_BURST_LEN)) || (span > 16'd4096);
      last_beat    = (cnt_q == len_q);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      acc     = resp_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr_aln;
               len_d  = cmd_len;
               cnt_d  = 8'd0;
               if (reject) begin
                  resp_d  = 2'b10;
                  state_d = S_DONE;
               end else begin
                  resp_d  = 2'b00;
                  state_d = cmd_rw ? S_WADDR : S_RADDR;
               end
            end
         end
         S_WADDR: if (M_AXI_AWREADY) state_d = S_WDATA;
         S_WDATA: begin
            if (wr_valid && M_AXI_WREADY) begin
               if (last_beat) state_d = S_WRESP;
               else           cnt_d   = cnt_q + 8'd1;
            end
         end
         S_WRESP: begin
            if (M_AXI_BVALID) begin
               resp_d  = M_AXI_BRESP;
               state_d = S_DONE;
            end
         end
         S_RADDR: if (M_AXI_ARREADY) state_d = S_RDATA;
         S_RDATA: begin
            if (M_AXI_RVALID && rd_ready) begin
               // Worst response wins; a misplaced RLAST counts as at least SLVERR.
               acc = (M_AXI_RRESP > resp_q) ? M_AXI_RRESP : resp_q;
               if ((M_AXI_RLAST != last_beat) && (acc < 2'b10)) acc = 2'b10;
               resp_d = acc;
               if (last_beat) state_d = S_DONE;
               else           cnt_d   = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= 8'd0;
         cnt_q   <= 8'd0;
         resp_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   assign cmd_ready     = (state_q == S_IDLE);
   assign done_valid    = (state_q == S_DONE);
   assign done_resp     = resp_q;
   assign dbg_state     = state_q;

   assign M_AXI_AWID    = '0;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWLEN   = len_q;
   assign M_AXI_AWSIZE  = 3'(LSB);
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0010;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWQOS   = 4'b0000;
   assign M_AXI_AWVALID = (state_q == S_WADDR);

   assign M_AXI_WDATA   = wr_data;
   assign M_AXI_WSTRB   = wr_strb;
   assign M_AXI_WLAST   = (state_q == S_WDATA) && last_beat;
   assign M_AXI_WVALID  = (state_q == S_WDATA) && wr_valid;
   assign wr_ready      = (state_q == S_WDATA) && M_AXI_WREADY;
   assign M_AXI_BREADY  = (state_q == S_WRESP);

   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = len_q;
   assign M_AXI_ARSIZE  = 3'(LSB);
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'b0010;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'b0000;
   assign M_AXI_ARVALID = (state_q == S_RADDR);

   assign rd_valid      = (state_q == S_RDATA) && M_AXI_RVALID;
   assign M_AXI_RREADY  = (state_q == S_RDATA) && rd_ready;
   assign rd_data       = M_AXI_RDATA;
   assign rd_last       = (state_q == S_RDATA) && last_beat;

   assign unused_ok     = ^{M_AXI_BID, M_AXI_RID};

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: the bench plays both the core-side engine and the AXI slave.
module tb_axi_burst_master;
   localparam int DW   = 32;
   localparam int AWD  = 32;
   localparam int MAXL = 16;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic aresetn;
   logic cmd_valid, cmd_ready, cmd_rw;
   logic [AWD-1:0] cmd_addr;
   logic [7:0] cmd_len;
   logic wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic [DW/8-1:0] wr_strb;
   logic rd_valid, rd_ready, rd_last;
   logic [DW-1:0] rd_data;
   logic done_valid;
   logic [1:0] done_resp;
   logic [0:0] awid, arid, bid, rid;
   logic [AWD-1:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize, awprot, arprot;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awlock, arlock;
   logic [3:0] awcache, arcache, awqos, arqos;
   logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic arvalid, arready, rvalid, rready, rlast;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [2:0] dbg_state;

   int total = 0;
   int bad = 0;
   logic [DW/8+DW-1:0] exp_q[$];

   axi_burst_master dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done_valid(done_valid), .done_resp(done_resp),
      .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
      .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
      .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
      .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .dbg_state(dbg_state)
   );

   function automatic bit model_reject(input logic [31:0] a, input logic [7:0] len);
      int span;
      span = int'(a[11:0]) + (int'(len) + 1) * (DW / 8);
      return (int'(len) >= MAXL) || (span > 4096);
   endfunction

   task automatic clear_inputs();
      cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_len = 0;
      wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
      arready = 0; rid = 0; rdata = '0; rresp = 0; rlast = 0; rvalid = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      aresetn = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      aresetn = 1;
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
      end
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready, done_valid} !== 8'h00) begin
         bad++;
         $display("FAIL reset_valids got=%b exp=00000000",
                  {awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready, done_valid});
      end
      total++;
      if (done_resp !== 2'b00) begin
         bad++; $display("FAIL reset_done_resp got=%b exp=00", done_resp);
      end
   endtask

   // One full command: bench acts as core and slave, checks every bus and stream beat.
   task automatic run_cmd(input logic rw, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] b_resp, input int err_beat, input logic [1:0] err_val,
                          input int early_last, input bit rnd, input int rst_beat);
      bit rej, aw_done, ar_done, w_done, b_done, fin, w_hold, r_hold;
      logic [1:0] exp_resp;
      logic [31:0] exp_addr;
      logic [DW/8+DW-1:0] item;
      int cyc, last_hs, wp, wi, rp, ri;
      exp_addr = (addr + BASE) & ~32'h3;
      rej = model_reject(exp_addr, len);
      if (rej) exp_resp = 2'b10;
      else if (rw) exp_resp = b_resp;
      else begin
         exp_resp = 2'b00;
         if (err_beat >= 0 && err_beat <= int'(len)) exp_resp = err_val;
         if (early_last >= 0 && early_last < int'(len) && exp_resp < 2'b10) exp_resp = 2'b10;
      end
      aw_done = 0; ar_done = 0; w_done = 0; b_done = 0; fin = 0; w_hold = 0; r_hold = 0;
      cyc = 0; last_hs = 0; wp = 0; wi = 0; rp = 0; ri = 0;

      @(negedge clk);
      cmd_valid = 1; cmd_rw = rw; cmd_addr = addr; cmd_len = len;
      #1;
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++; $display("FAIL cmd_ready got=%b exp=1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 0;

      while (!fin && cyc < 2000) begin
         cyc++;
         if (rst_beat >= 0 && aw_done && wi == rst_beat) begin
            aresetn = 0;
            @(posedge clk);
            #1;
            total++;
            if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, wr_ready, done_valid, done_resp}
                !== 10'b1000000000) begin
               bad++;
               $display("FAIL midreset_outputs got=%b exp=1000000000",
                        {cmd_ready, awvalid, wvalid, bready, arvalid, rready, wr_ready, done_valid, done_resp});
            end
            @(negedge clk);
            aresetn = 1;
            clear_inputs();
            exp_q.delete();
            return;
         end
         awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         rd_ready = rnd ? 1'(cyc % 2) : 1'b1;
         if (!w_hold) begin
            wr_valid = 0;
            if (rw && !rej && wp <= int'(len) && (!rnd || $urandom_range(0, 3) != 0)) begin
               wr_valid = 1; wr_data = $urandom; wr_strb = 4'($urandom_range(0, 15));
               exp_q.push_back({wr_strb, wr_data});
               wp++;
            end
         end
         bvalid = w_done && !b_done;
         bresp  = b_resp;
         if (!r_hold) begin
            rvalid = 0;
            if (ar_done && rp <= int'(len) && (!rnd || $urandom_range(0, 2) != 0)) begin
               rvalid = 1; rdata = $urandom;
               rresp = (rp == err_beat) ? err_val : 2'b00;
               rlast = (rp == int'(len)) || (rp == early_last);
               exp_q.push_back({4'h0, rdata});
               rp++;
            end
         end
         #1;
         if (awvalid) begin
            total++;
            if (rej || !rw || aw_done) begin
               bad++; $display("FAIL aw_unexpected got=1 exp=0 cyc=%0d", cyc);
            end else if (awready) begin
               aw_done = 1;
               total++;
               if ({awaddr, awlen, awsize, awburst, awcache} !== {exp_addr, len, 3'd2, 2'b01, 4'b0010}) begin
                  bad++;
                  $display("FAIL aw_fields got=%h/%h/%h/%b/%b exp=%h/%h/2/01/0010",
                           awaddr, awlen, awsize, awburst, awcache, exp_addr, len);
               end
            end
         end
         if (arvalid) begin
            total++;
            if (rej || rw || ar_done) begin
               bad++; $display("FAIL ar_unexpected got=1 exp=0 cyc=%0d", cyc);
            end else if (arready) begin
               ar_done = 1;
               total++;
               if ({araddr, arlen, arsize, arburst, arcache} !== {exp_addr, len, 3'd2, 2'b01, 4'b0010}) begin
                  bad++;
                  $display("FAIL ar_fields got=%h/%h/%h/%b/%b exp=%h/%h/2/01/0010",
                           araddr, arlen, arsize, arburst, arcache, exp_addr, len);
               end
            end
         end
         if (wvalid && !aw_done) begin
            total++; bad++; $display("FAIL w_before_aw got=1 exp=0 cyc=%0d", cyc);
         end
         if (wvalid && wready) begin
            item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if ({wstrb, wdata} !== item) begin
               bad++; $display("FAIL w_beat%0d got=%h exp=%h", wi, {wstrb, wdata}, item);
            end
            total++;
            if (wlast !== (wi == int'(len))) begin
               bad++; $display("FAIL wlast_beat%0d got=%b exp=%b", wi, wlast, wi == int'(len));
            end
            if (wi == int'(len)) w_done = 1;
            wi++;
         end
         w_hold = wr_valid && !wr_ready;
         if (bvalid && bready) begin
            b_done = 1; last_hs = cyc;
         end
         r_hold = rvalid && !rready;
         if (rd_valid && rd_ready) begin
            item = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if ({4'h0, rd_data} !== item) begin
               bad++; $display("FAIL rd_beat%0d got=%h exp=%h", ri, rd_data, item);
            end
            total++;
            if (rd_last !== (ri == int'(len))) begin
               bad++; $display("FAIL rd_last_beat%0d got=%b exp=%b", ri, rd_last, ri == int'(len));
            end
            if (ri == int'(len)) last_hs = cyc;
            ri++;
         end
         if (done_valid) begin
            fin = 1;
            total++;
            if (done_resp !== exp_resp) begin
               bad++; $display("FAIL done_resp got=%b exp=%b", done_resp, exp_resp);
            end
            total++;
            if (cyc !== last_hs + 1) begin
               bad++; $display("FAIL done_latency got=%0d exp=%0d", cyc, last_hs + 1);
            end
         end
         @(negedge clk);
      end
      clear_inputs();
      total++;
      if (!fin) begin
         bad++; $display("FAIL done_timeout got=none exp=pulse");
      end
      #1;
      total++;
      if ({done_valid, cmd_ready} !== 2'b01) begin
         bad++; $display("FAIL after_done got=%b exp=01", {done_valid, cmd_ready});
      end
      total++;
      if ((rej ? 0 : int'(len) + 1) !== (rw ? wi : ri) || exp_q.size() != 0) begin
         bad++;
         $display("FAIL beat_count got=%0d left=%0d exp=%0d", rw ? wi : ri, exp_q.size(),
                  rej ? 0 : int'(len) + 1);
      end
      exp_q.delete();
   endtask

   task automatic test_write_basic();
      run_cmd(1'b1, 32'h100, 8'd3, 2'b00, -1, 2'b00, -1, 1'b0, -1);
   endtask

   task automatic test_read_stream();
      run_cmd(1'b0, 32'h200, 8'd15, 2'b00, -1, 2'b00, -1, 1'b1, -1);
   endtask

   task automatic test_reject_len();
      run_cmd(1'b1, 32'h0, 8'd16, 2'b00, -1, 2'b00, -1, 1'b0, -1);
      run_cmd(1'b0, 32'h0, 8'd15, 2'b00, -1, 2'b00, -1, 1'b0, -1);
   endtask

   task automatic test_4k_boundary();
      run_cmd(1'b0, 32'hFF8, 8'd3, 2'b00, -1, 2'b00, -1, 1'b0, -1);
      run_cmd(1'b0, 32'hFF0, 8'd3, 2'b00, -1, 2'b00, -1, 1'b0, -1);
   endtask

   task automatic test_read_errors();
      run_cmd(1'b0, 32'h300, 8'd3, 2'b00, 1, 2'b10, -1, 1'b0, -1);
      run_cmd(1'b0, 32'h300, 8'd3, 2'b00, -1, 2'b00, 1, 1'b0, -1);
      run_cmd(1'b0, 32'h340, 8'd3, 2'b00, 2, 2'b11, -1, 1'b1, -1);
   endtask

   task automatic test_reset_mid();
      run_cmd(1'b1, 32'h400, 8'd3, 2'b00, -1, 2'b00, -1, 1'b0, 1);
      run_cmd(1'b1, 32'h400, 8'd3, 2'b00, -1, 2'b00, -1, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         run_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), 8'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), -1, 2'b00, -1, 1'b1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_stream();
      test_reject_len();
      test_4k_boundary();
      test_read_errors();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
